wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the pipelined datapath. It takes the MEM/WB pipeline register outputs, selects the write-back value and destination, and commits them into a 32 x 32-bit register file. It serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass. It also holds a one-entry registered copy of the last committed write, which the EX-stage forwarding unit uses as a third forwarding source.

## Interface
- DATA_W, 32, register and data width
- NREG, 32, number of registers; address width is log2(NREG) = 5
- LINK_REG, 31, destination forced on JAL

- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all state
- in_RegWrite  input  1  write enable from MEM/WB
- in_MemToReg  input  1  1 = write DataMemOut, 0 = write ALU_output
- in_JALSrc  input  1  1 = JAL link write
- in_DestReg  input  5  destination register number
- in_DataMemOut  input  32  load data
- in_ALU_output  input  32  ALU result, or link address when JALSrc = 1
- in_ReadReg1, in_ReadReg2  input  5 each  ID-stage read addresses
- out_ReadData1, out_ReadData2  output  32 each  read data (combinational)
- out_WBData  output  32  value committed on the previous edge (registered)
- out_WBDest  output  5  destination committed on the previous edge (registered)
- out_WBValid  output  1  previous edge performed a real write (registered)
- out_WriteCount  output  16  count of committed writes, wraps

## Operation
- Write-back selection (combinational):
  - wb_dest = in_JALSrc ? LINK_REG : in_DestReg
  - wb_data = (in_MemToReg & ~in_JALSrc) ? in_DataMemOut : in_ALU_output
  - JALSrc overrides MemToReg.
- Write is effective only when in_RegWrite = 1 and wb_dest != 0.
- Effective write: on the rising edge, regs[wb_dest] <= wb_data.
- Register 0 never changes and always reads 0, even if a write targets it.
- Read port n:
  - in_ReadRegn = 0 -> 0.
  - Else, if an effective write is pending this cycle and wb_dest = in_ReadRegn -> wb_data (bypass).
  - Else -> regs[in_ReadRegn].
- Forwarding register, on each edge:
  - out_WBValid <= effective write.
  - out_WBDest <= effective ? wb_dest : 0.
  - out_WBData <= effective ? wb_data : 0.
- out_WriteCount increments by 1 on each effective write; 16'hFFFF wraps to 0.
- Suppressed writes (RegWrite = 0, or wb_dest = 0) change nothing except out_WBValid/out_WBDest/out_WBData, which go to 0.

## Timing
- Reset (asynchronous, takes effect immediately, independent of Clk):
  - all regs = 0
  - out_WBData = 0, out_WBDest = 0, out_WBValid = 0, out_WriteCount = 0
  - read outputs therefore read 0
- Reset asserted mid-write: the write is lost. The first write after deassertion commits on the first rising edge where Reset = 0.
- Write latency: committed at the rising edge that ends the cycle in which the MEM/WB outputs are presented. It is visible to reads in that same cycle through the bypass, and to reads from the register array in later cycles.
- Forwarding outputs are valid for exactly one cycle after the commit edge and are overwritten on the next edge.
- Read ports have no clocked latency.
- Both read ports may address the same register, and either may match wb_dest simultaneously; both return wb_data.
- No stall or handshake: one write-back per cycle, unconditionally.

## Test plan
- Reset -> all reads 0, WBValid 0, WriteCount 0.
  - Then Reset = 0 and write R5 = 0xDEADBEEF (RegWrite = 1, MemToReg = 0).
  - Next cycle: ReadReg1 = 5 returns 0xDEADBEEF; WBDest = 5, WBValid = 1, WriteCount = 1.
- Same-cycle bypass:
  - Write R7 = 0x12345678 via MemToReg = 1, with ReadReg1 = ReadReg2 = 7 in the same cycle.
  - Both outputs are 0x12345678 before the edge; R7 still holds it afterwards.
- $0 protection:
  - Write R0 = 0xFFFFFFFF with RegWrite = 1.
  - ReadReg1 = 0 returns 0 in the same cycle and afterwards; WBValid 0; WriteCount unchanged.
- JAL override:
  - JALSrc = 1, DestReg = 3, MemToReg = 1, ALU_output = 0x00400008, DataMemOut = 0xAAAA.
  - R31 = 0x00400008; R3 unchanged; WBDest = 31.
- Suppressed write:
  - RegWrite = 0, DestReg = 9, data 0x55.
  - R9 unchanged; WBValid 0, WBDest 0, WBData 0.
- Async reset mid-operation:
  - Write R4 = 0x1, then assert Reset between edges.
  - Outputs clear before the next edge; R4 reads 0 after release.
  - Also preload WriteCount to 0xFFFF by forcing it, then do one write -> WriteCount = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value and destination, commits it
// into a 32 x 32 register file with bypassed combinational reads, and keeps a
// registered copy of the last committed write for EX-stage forwarding.
module wb_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned LINK_REG = 31,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_RegWrite,
  input  logic              in_MemToReg,
  input  logic              in_JALSrc,
  input  logic [AW-1:0]     in_DestReg,
  input  logic [DATA_W-1:0] in_DataMemOut,
  input  logic [DATA_W-1:0] in_ALU_output,
  input  logic [AW-1:0]     in_ReadReg1,
  input  logic [AW-1:0]     in_ReadReg2,
  output logic [DATA_W-1:0] out_ReadData1,
  output logic [DATA_W-1:0] out_ReadData2,
  output logic [DATA_W-1:0] out_WBData,
  output logic [AW-1:0]     out_WBDest,
  output logic              out_WBValid,
  output logic [CNT_W-1:0]  out_WriteCount
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [AW-1:0]     wb_dest_q, wb_dest_d;
  logic              wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [AW-1:0]     wb_dest_c;
  logic [DATA_W-1:0] wb_data_c;
  logic              wr_en_c;

  // Write-back mux: JAL forces the link register and the link address.
  // A write presented while Reset is high is dropped, so it is not bypassed.
  always_comb begin
    wb_dest_c = in_JALSrc ? AW'(LINK_REG) : in_DestReg;
    wb_data_c = (in_MemToReg && !in_JALSrc) ? in_DataMemOut : in_ALU_output;
    wr_en_c   = in_RegWrite && (wb_dest_c != '0) && !Reset;
  end

  // Read ports: $0 reads zero, a pending write to the same register is bypassed.
  always_comb begin
    out_ReadData1 = '0;
    out_ReadData2 = '0;
    if (in_ReadReg1 != '0) begin
      if (wr_en_c && (wb_dest_c == in_ReadReg1)) out_ReadData1 = wb_data_c;
      else                                       out_ReadData1 = regs_q[in_ReadReg1];
    end
    if (in_ReadReg2 != '0) begin
      if (wr_en_c && (wb_dest_c == in_ReadReg2)) out_ReadData2 = wb_data_c;
      else                                       out_ReadData2 = regs_q[in_ReadReg2];
    end
  end

  // Next state of the forwarding copy and the commit counter.
  always_comb begin
    wb_valid_d = wr_en_c;
    wb_dest_d  = '0;
    wb_data_d  = '0;
    cnt_d      = cnt_q;
    if (wr_en_c) begin
      wb_dest_d = wb_dest_c;
      wb_data_d = wb_data_c;
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  // Register array; entry 0 is only ever cleared.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      regs_q[wb_dest_c] <= wb_data_c;
    end
  end

  // Forwarding register and write counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_WBValid    = wb_valid_q;
  assign out_WBDest     = wb_dest_q;
  assign out_WBData     = wb_data_q;
  assign out_WriteCount = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_RegWrite = 1'b0;
  logic        in_MemToReg = 1'b0;
  logic        in_JALSrc = 1'b0;
  logic [4:0]  in_DestReg = '0;
  logic [31:0] in_DataMemOut = '0;
  logic [31:0] in_ALU_output = '0;
  logic [4:0]  in_ReadReg1 = '0;
  logic [4:0]  in_ReadReg2 = '0;
  logic [31:0] out_ReadData1, out_ReadData2, out_WBData;
  logic [4:0]  out_WBDest;
  logic        out_WBValid;
  logic [15:0] out_WriteCount;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile dut (
    .Clk(Clk), .Reset(Reset),
    .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_JALSrc(in_JALSrc),
    .in_DestReg(in_DestReg), .in_DataMemOut(in_DataMemOut), .in_ALU_output(in_ALU_output),
    .in_ReadReg1(in_ReadReg1), .in_ReadReg2(in_ReadReg2),
    .out_ReadData1(out_ReadData1), .out_ReadData2(out_ReadData2),
    .out_WBData(out_WBData), .out_WBDest(out_WBDest), .out_WBValid(out_WBValid),
    .out_WriteCount(out_WriteCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] dst, input logic mtr, input logic jal,
                    input logic [31:0] alu, input logic [31:0] dmo);
    in_RegWrite   = 1'b1;
    in_DestReg    = dst;
    in_MemToReg   = mtr;
    in_JALSrc     = jal;
    in_ALU_output = alu;
    in_DataMemOut = dmo;
  endtask

  task automatic idle();
    in_RegWrite = 1'b0;
    in_MemToReg = 1'b0;
    in_JALSrc   = 1'b0;
  endtask

  initial begin
    // Reset state
    in_ReadReg1 = 5'd5;
    in_ReadReg2 = 5'd31;
    #3;
    chk("rst_rd1", out_ReadData1, 32'h0);
    chk("rst_rd2", out_ReadData2, 32'h0);
    chk("rst_valid", 32'(out_WBValid), 32'h0);
    chk("rst_cnt", 32'(out_WriteCount), 32'h0);
    step();
    Reset = 1'b0;

    // Basic write R5 = DEADBEEF
    wr(5'd5, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    step();
    idle();
    #1;
    chk("r5_rd1", out_ReadData1, 32'hDEADBEEF);
    chk("r5_dest", 32'(out_WBDest), 32'd5);
    chk("r5_valid", 32'(out_WBValid), 32'd1);
    chk("r5_data", out_WBData, 32'hDEADBEEF);
    chk("r5_cnt", 32'(out_WriteCount), 32'd1);

    // Same-cycle bypass on both ports, load data selected
    wr(5'd7, 1'b1, 1'b0, 32'h0BAD0BAD, 32'h12345678);
    in_ReadReg1 = 5'd7;
    in_ReadReg2 = 5'd7;
    #1;
    chk("byp_rd1", out_ReadData1, 32'h12345678);
    chk("byp_rd2", out_ReadData2, 32'h12345678);
    step();
    idle();
    #1;
    chk("r7_rd1", out_ReadData1, 32'h12345678);
    chk("r7_rd2", out_ReadData2, 32'h12345678);
    chk("r7_cnt", 32'(out_WriteCount), 32'd2);

    // Writes to $0 are dropped
    wr(5'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    in_ReadReg1 = 5'd0;
    #1;
    chk("r0_byp", out_ReadData1, 32'h0);
    step();
    idle();
    #1;
    chk("r0_rd", out_ReadData1, 32'h0);
    chk("r0_valid", 32'(out_WBValid), 32'h0);
    chk("r0_dest", 32'(out_WBDest), 32'h0);
    chk("r0_cnt", 32'(out_WriteCount), 32'd2);

    // JAL forces R31 and ALU value even with MemToReg set
    wr(5'd3, 1'b1, 1'b1, 32'h00400008, 32'h0000AAAA);
    in_ReadReg1 = 5'd31;
    in_ReadReg2 = 5'd3;
    #1;
    chk("jal_byp31", out_ReadData1, 32'h00400008);
    chk("jal_byp3", out_ReadData2, 32'h0);
    step();
    idle();
    #1;
    chk("jal_r31", out_ReadData1, 32'h00400008);
    chk("jal_r3", out_ReadData2, 32'h0);
    chk("jal_dest", 32'(out_WBDest), 32'd31);
    chk("jal_data", out_WBData, 32'h00400008);
    chk("jal_cnt", 32'(out_WriteCount), 32'd3);

    // Suppressed write (RegWrite = 0)
    in_RegWrite   = 1'b0;
    in_DestReg    = 5'd9;
    in_ALU_output = 32'h55;
    in_DataMemOut = 32'h55;
    in_ReadReg1   = 5'd9;
    #1;
    chk("sup_byp", out_ReadData1, 32'h0);
    step();
    #1;
    chk("sup_r9", out_ReadData1, 32'h0);
    chk("sup_valid", 32'(out_WBValid), 32'h0);
    chk("sup_dest", 32'(out_WBDest), 32'h0);
    chk("sup_data", out_WBData, 32'h0);
    chk("sup_cnt", 32'(out_WriteCount), 32'd3);

    // Async reset between edges, with a write pending
    wr(5'd4, 1'b0, 1'b0, 32'h1, 32'h0);
    step();
    in_ReadReg1 = 5'd4;
    in_ReadReg2 = 5'd6;
    wr(5'd6, 1'b0, 1'b0, 32'h2, 32'h0);
    #1;
    chk("pre_r4", out_ReadData1, 32'h1);
    chk("pre_valid", 32'(out_WBValid), 32'h1);
    Reset = 1'b1;
    #1;
    chk("ar_r4", out_ReadData1, 32'h0);
    chk("ar_r6", out_ReadData2, 32'h0);
    chk("ar_valid", 32'(out_WBValid), 32'h0);
    chk("ar_data", out_WBData, 32'h0);
    chk("ar_cnt", 32'(out_WriteCount), 32'h0);
    step();
    Reset = 1'b0;
    idle();
    #1;
    chk("rel_r4", out_ReadData1, 32'h0);
    chk("rel_r6", out_ReadData2, 32'h0);
    wr(5'd6, 1'b0, 1'b0, 32'h2, 32'h0);
    step();
    idle();
    #1;
    chk("post_r6", out_ReadData2, 32'h2);
    chk("post_cnt", 32'(out_WriteCount), 32'd1);

    // Counter wrap: drive it to FFFF, then one more write returns it to 0
    for (int i = 0; i < 65534; i++) begin
      wr(5'd8, 1'b0, 1'b0, 32'(i), 32'h0);
      step();
    end
    idle();
    in_ReadReg1 = 5'd8;
    #1;
    chk("wrap_ffff", 32'(out_WriteCount), 32'h0000FFFF);
    chk("wrap_r8", out_ReadData1, 32'd65533);
    wr(5'd10, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0);
    step();
    idle();
    in_ReadReg2 = 5'd10;
    #1;
    chk("wrap_zero", 32'(out_WriteCount), 32'h0);
    chk("wrap_r10", out_ReadData2, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
